// File: rtl/kaipokrandt_isa_pkg.sv
// -----------------------------------------------------------------------------
// kaipokrandt_isa_pkg
// Shared ISA definitions for the execution datapath and its sequencers:
//   - instruction width and fixed IR field bit positions
//   - instruction class codes (IR[15:12])
//   - ALU operation codes (IR[11:8] for ALU classes)
//   - helper to extract the class field from an instruction word
// No ports; imported with `import kaipokrandt_isa_pkg::*;`.
// -----------------------------------------------------------------------------
package kaipokrandt_isa_pkg;

  localparam int ISA_IW = 16;

  // IR field positions: [15:12] class, [11:8] alu_op, [7:4] dst, [3:0] src
  localparam int IR_CLS_MSB = 15;
  localparam int IR_CLS_LSB = 12;
  localparam int IR_OP_MSB  = 11;
  localparam int IR_OP_LSB  = 8;
  localparam int IR_DST_MSB = 7;
  localparam int IR_DST_LSB = 4;
  localparam int IR_SRC_MSB = 3;
  localparam int IR_SRC_LSB = 0;

  // Instruction class codes
  localparam logic [3:0] CLS_NOP     = 4'h0;
  localparam logic [3:0] CLS_ALU_REG = 4'h1;
  localparam logic [3:0] CLS_ALU_IMM = 4'h2;
  localparam logic [3:0] CLS_LOAD    = 4'h3;
  localparam logic [3:0] CLS_STORE   = 4'h4;
  localparam logic [3:0] CLS_JMP     = 4'h5;
  localparam logic [3:0] CLS_HALT    = 4'hF;

  // ALU operation codes carried in the alu_op field
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOT = 4'h5,
    ALU_SHL = 4'h6,
    ALU_SHR = 4'h7,
    ALU_MOV = 4'h8,
    ALU_CMP = 4'h9,
    ALU_INC = 4'hA,
    ALU_DEC = 4'hB
  } alu_op_e;

  function automatic logic [3:0] ir_class(input logic [ISA_IW-1:0] ir);
    return ir[IR_CLS_MSB:IR_CLS_LSB];
  endfunction

endpackage

// File: rtl/kaipokrandt_fsm_fetch_dispatch_class_decode.sv
// -----------------------------------------------------------------------------
// kaipokrandt_class_decode
// Purely combinational decode of a 4-bit instruction class into one-hot
// dispatch strobes plus NOP / HALT / illegal flags. Exactly one output is
// high for any input value.
// Ports:
//   cls_i       in  4  instruction class
//   alu_reg_o   out 1  class ALU register
//   alu_imm_o   out 1  class ALU immediate
//   mem_o       out 1  class LOAD or STORE
//   jmp_o       out 1  class JMP
//   nop_o       out 1  class NOP
//   halt_o      out 1  class HALT
//   illegal_o   out 1  any unassigned class
// -----------------------------------------------------------------------------
module kaipokrandt_class_decode
  import kaipokrandt_isa_pkg::*;
(
  input  logic [3:0] cls_i,
  output logic       alu_reg_o,
  output logic       alu_imm_o,
  output logic       mem_o,
  output logic       jmp_o,
  output logic       nop_o,
  output logic       halt_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_reg_o = 1'b0;
    alu_imm_o = 1'b0;
    mem_o     = 1'b0;
    jmp_o     = 1'b0;
    nop_o     = 1'b0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_NOP:             nop_o     = 1'b1;
      CLS_ALU_REG:         alu_reg_o = 1'b1;
      CLS_ALU_IMM:         alu_imm_o = 1'b1;
      CLS_LOAD, CLS_STORE: mem_o     = 1'b1;
      CLS_JMP:             jmp_o     = 1'b1;
      CLS_HALT:            halt_o    = 1'b1;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/kaipokrandt_fsm_fetch_dispatch.sv
// -----------------------------------------------------------------------------
// kaipokrandt_fsm_fetch_dispatch
// Upstream sequencer for the execution FSMs. Fetches one instruction word over
// the shared bus, latches it, decodes its class, issues a one-cycle start pulse
// with stable class strobes, and waits for the execution FSM's done pulse.
// Owns PC increment, HALT and error (illegal class, memory or execution timeout).
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low
//   run          in   1   level; enables fetching from idle
//   instr_in     in   IW  MDR contents, valid when mem_ready is seen
//   mem_ready    in   1   memory read complete
//   exec_done    in   1   OR of all execution-FSM done pulses
//   pc_out_en    out  1   PC drives bus (only bus driver asserted here)
//   mar_ld       out  1   MAR loads from bus
//   mem_rd       out  1   memory read request, held while waiting
//   ir_ld        out  1   IR loads instr_in
//   pc_inc       out  1   PC += 1
//   start        out  1   one-cycle dispatch pulse
//   dec_alu_reg  out  1   class ALU register strobe
//   dec_alu_imm  out  1   class ALU immediate strobe
//   dec_mem      out  1   class LOAD/STORE strobe
//   dec_jmp      out  1   class JMP strobe
//   alu_op_out   out  4   registered alu_op field
//   dst_sel      out  4   registered dst field
//   src_sel      out  4   registered src field
//   busy         out  1   high except in idle, halt, error
//   halted       out  1   high in halt
//   err          out  1   high in error
// -----------------------------------------------------------------------------
module kaipokrandt_fsm_fetch_dispatch
  import kaipokrandt_isa_pkg::*;
#(
  parameter int IW           = ISA_IW,
  parameter int MEM_TIMEOUT  = 15,
  parameter int EXEC_TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [IW-1:0] instr_in,
  input  logic          mem_ready,
  input  logic          exec_done,
  output logic          pc_out_en,
  output logic          mar_ld,
  output logic          mem_rd,
  output logic          ir_ld,
  output logic          pc_inc,
  output logic          start,
  output logic          dec_alu_reg,
  output logic          dec_alu_imm,
  output logic          dec_mem,
  output logic          dec_jmp,
  output logic [3:0]    alu_op_out,
  output logic [3:0]    dst_sel,
  output logic [3:0]    src_sel,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FADDR  = 4'd1,
    S_FWAIT  = 4'd2,
    S_FLATCH = 4'd3,
    S_DEC    = 4'd4,
    S_DISP   = 4'd5,
    S_WAIT   = 4'd6,
    S_HALT   = 4'd7,
    S_ERR    = 4'd8
  } state_e;

  // The wait counter reads 0 on the first cycle of a wait state, so the last
  // cycle allowed without the awaited event has count TIMEOUT-1.
  localparam logic [7:0] MEM_LIM  = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] EXEC_LIM = 8'(EXEC_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cls_q, alu_op_q, dst_q, src_q;

  logic cd_alu_reg, cd_alu_imm, cd_mem, cd_jmp, cd_nop, cd_halt, cd_illegal;
  logic strobe_window;

  kaipokrandt_class_decode u_class_decode (
    .cls_i     (cls_q),
    .alu_reg_o (cd_alu_reg),
    .alu_imm_o (cd_alu_imm),
    .mem_o     (cd_mem),
    .jmp_o     (cd_jmp),
    .nop_o     (cd_nop),
    .halt_o    (cd_halt),
    .illegal_o (cd_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      // NOTE: decode registers are reset so the field outputs read 0, not X, out of reset.
      cls_q    <= '0;
      alu_op_q <= '0;
      dst_q    <= '0;
      src_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_FLATCH) begin
        cls_q    <= ir_class(instr_in[ISA_IW-1:0]);
        alu_op_q <= instr_in[IR_OP_MSB:IR_OP_LSB];
        dst_q    <= instr_in[IR_DST_MSB:IR_DST_LSB];
        src_q    <= instr_in[IR_SRC_MSB:IR_SRC_LSB];
      end
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_d   = state_q;
    pc_out_en = 1'b0;
    mar_ld    = 1'b0;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    start     = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FADDR;
      end
      S_FADDR: begin
        pc_out_en = 1'b1;
        mar_ld    = 1'b1;
        state_d   = S_FWAIT;
      end
      S_FWAIT: begin
        mem_rd = 1'b1;
        // A ready on the final allowed cycle still wins over the timeout.
        if (mem_ready)              state_d = S_FLATCH;
        else if (cnt_q >= MEM_LIM)  state_d = S_ERR;
      end
      S_FLATCH: begin
        ir_ld   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        pc_inc = 1'b1;
        if (cd_nop)          state_d = S_IDLE;
        else if (cd_halt)    state_d = S_HALT;
        else if (cd_illegal) state_d = S_ERR;
        else                 state_d = S_DISP;
      end
      S_DISP: begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done)              state_d = S_IDLE;
        else if (cnt_q >= EXEC_LIM) state_d = S_ERR;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: state_d = S_ERR;
    endcase
  end

  // Wait counter: cleared on every state change (hence on entry to both wait
  // states), otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);

  // Strobes only show while the execution FSM owns the instruction.
  assign strobe_window = (state_q == S_DISP) || (state_q == S_WAIT);
  assign dec_alu_reg   = strobe_window & cd_alu_reg;
  assign dec_alu_imm   = strobe_window & cd_alu_imm;
  assign dec_mem       = strobe_window & cd_mem;
  assign dec_jmp       = strobe_window & cd_jmp;

  assign alu_op_out = alu_op_q;
  assign dst_sel    = dst_q;
  assign src_sel    = src_q;

endmodule

// File: tb/tb_kaipokrandt_fsm_fetch_dispatch.sv
// -----------------------------------------------------------------------------
// tb_kaipokrandt_fsm_fetch_dispatch
// Self-checking bench: directed scenarios followed by randomized instruction
// transactions. A transaction-level model predicts, from the instruction class
// and the chosen memory/exec latencies, which control outputs appear on which
// cycle, the strobe pattern, and running totals of pc_inc and start pulses.
// -----------------------------------------------------------------------------
module tb_kaipokrandt_fsm_fetch_dispatch;

  localparam int MEM_TO  = 15;
  localparam int EXEC_TO = 63;

  typedef enum {O_NOP, O_DISP, O_HALT, O_ILL} outcome_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        pc_out_en, mar_ld, mem_rd, ir_ld, pc_inc, start;
  logic        dec_alu_reg, dec_alu_imm, dec_mem, dec_jmp;
  logic [3:0]  alu_op_out, dst_sel, src_sel;
  logic        busy, halted, err;

  int n_checks = 0;
  int n_errors = 0;
  int pc_inc_seen = 0, start_seen = 0, onehot_viol = 0;
  int exp_pc_inc = 0, exp_start = 0;

  kaipokrandt_fsm_fetch_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr_in    (instr_in),
    .mem_ready   (mem_ready),
    .exec_done   (exec_done),
    .pc_out_en   (pc_out_en),
    .mar_ld      (mar_ld),
    .mem_rd      (mem_rd),
    .ir_ld       (ir_ld),
    .pc_inc      (pc_inc),
    .start       (start),
    .dec_alu_reg (dec_alu_reg),
    .dec_alu_imm (dec_alu_imm),
    .dec_mem     (dec_mem),
    .dec_jmp     (dec_jmp),
    .alu_op_out  (alu_op_out),
    .dst_sel     (dst_sel),
    .src_sel     (src_sel),
    .busy        (busy),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  wire [3:0]  strobes  = {dec_alu_reg, dec_alu_imm, dec_mem, dec_jmp};
  wire [24:0] all_outs = {pc_out_en, mar_ld, mem_rd, ir_ld, pc_inc, start, strobes,
                          alu_op_out, dst_sel, src_sel, busy, halted, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: class -> outcome and strobe pattern ----
  function automatic outcome_e outcome(input logic [3:0] cls);
    if (cls == 4'h0)                  return O_NOP;
    if (cls == 4'hF)                  return O_HALT;
    if (cls >= 4'h1 && cls <= 4'h5)   return O_DISP;
    return O_ILL;
  endfunction

  // {alu_reg, alu_imm, mem, jmp}
  function automatic logic [3:0] exp_strobe(input logic [3:0] cls);
    case (cls)
      4'h1:       return 4'b1000;
      4'h2:       return 4'b0100;
      4'h3, 4'h4: return 4'b0010;
      4'h5:       return 4'b0001;
      default:    return 4'b0000;
    endcase
  endfunction

  // Advance one cycle; observe at the falling edge and tally pulses.
  task automatic step();
    @(negedge clk);
    if (pc_inc === 1'b1) pc_inc_seen++;
    if (start === 1'b1)  start_seen++;
    if ($countones(strobes) > 1) onehot_viol++;
  endtask

  // Assert reset mid-cycle, check outputs drop at once, then release.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    exec_done = 1'b0;
    #1;
    check("rst_async_zero", all_outs, 0);
    step();
    step();
    check("rst_held_zero", all_outs, 0);
    reset = 1'b1;
    step();
    check("post_rst_idle", {busy, halted, err}, 0);
  endtask

  // Terminal state: run toggling must have no effect; then leave via reset.
  task automatic terminal(input bit is_halt);
    string tag;
    logic [6:0] exp;
    tag = is_halt ? "halt_sticky" : "err_sticky";
    exp = is_halt ? 7'b1000000 : 7'b0100000;
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom);
      step();
      check(tag, {halted, err, busy, start, pc_inc, mem_rd, pc_out_en}, exp);
    end
    run = 1'b0;
    do_reset();
  endtask

  // One instruction from idle. mem_lat/exec_lat: index of the wait cycle on
  // which ready/done is given (>= timeout means never).
  task automatic do_instr(input logic [15:0] instr, input int mem_lat, input int exec_lat,
                          input bit stray, input bit rst_in_wait);
    outcome_e   oc;
    logic [3:0] exp_str;
    int         gap;
    oc      = outcome(instr[15:12]);
    exp_str = exp_strobe(instr[15:12]);
    gap     = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      step();
      check("idle_hold", {busy, pc_out_en, mem_rd}, 3'b000);
    end
    instr_in = instr;
    run = 1'b1;
    step();
    check("faddr", {pc_out_en, mar_ld, mem_rd, busy}, 4'b1101);
    run = 1'b0;
    for (int k = 0; k <= MEM_TO; k++) begin
      step();
      if (k == MEM_TO) begin
        mem_ready = 1'b0;
        exec_done = 1'b0;
        check("mem_timeout_err", {err, busy, mem_rd}, 3'b100);
        terminal(1'b0);
        return;
      end
      check("fwait_rd", {mem_rd, pc_out_en, mar_ld, busy}, 4'b1001);
      mem_ready = (k == mem_lat);
      exec_done = stray & 1'($urandom);
      if (k == mem_lat) break;
    end
    step();
    mem_ready = 1'b0;
    exec_done = stray & 1'($urandom);
    check("flatch", {ir_ld, mem_rd, pc_inc, busy}, 4'b1001);
    step();
    instr_in = 16'($urandom);
    exec_done = stray & 1'($urandom);
    exp_pc_inc++;
    check("dec_pc_inc", {pc_inc, ir_ld, start, busy}, 4'b1001);
    check("dec_fields", {alu_op_out, dst_sel, src_sel}, instr[11:0]);
    check("dec_no_strobe", strobes, 0);
    step();
    case (oc)
      O_NOP: begin
        exec_done = 1'b0;
        check("nop_idle", {busy, halted, err, start}, 0);
        return;
      end
      O_HALT: begin
        exec_done = 1'b0;
        check("halt_state", {halted, busy, err, start}, 4'b1000);
        terminal(1'b1);
        return;
      end
      O_ILL: begin
        exec_done = 1'b0;
        check("illegal_err", {err, busy, halted, start}, 4'b1000);
        terminal(1'b0);
        return;
      end
      default: ;
    endcase
    exp_start++;
    exec_done = stray & 1'($urandom);
    check("disp_start", {start, busy, strobes}, {2'b11, exp_str});
    check("disp_fields", {alu_op_out, dst_sel, src_sel}, instr[11:0]);
    for (int k = 0; k <= EXEC_TO; k++) begin
      step();
      if (k == EXEC_TO) begin
        exec_done = 1'b0;
        check("exec_timeout_err", {err, busy, start, strobes}, 7'b1000000);
        terminal(1'b0);
        return;
      end
      check("wait_strobes", {start, busy, strobes}, {2'b01, exp_str});
      if (rst_in_wait && k == 2) begin
        do_reset();
        return;
      end
      exec_done = (k == exec_lat);
      if (k == exec_lat) break;
    end
    step();
    exec_done = 1'b0;
    check("done_idle", {busy, start, strobes}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0;
    logic [3:0]  cls;
    logic [15:0] instr;
    int r, mem_lat, exec_lat;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", all_outs, 0);
    reset = 1'b1;
    step();
    check("idle_after_reset", {busy, halted, err}, 0);

    // ALU register instruction, done on the 5th wait cycle
    p0 = pc_inc_seen;
    do_instr(16'h1A21, 0, 4, 1'b0, 1'b0);
    check("alu_reg_one_pc_inc", 32'(pc_inc_seen - p0), 1);

    // NOP then HALT
    p0 = pc_inc_seen;
    s0 = start_seen;
    do_instr(16'h0000, 0, 0, 1'b0, 1'b0);
    do_instr(16'hF000, 1, 0, 1'b0, 1'b0);
    check("nop_halt_pc_inc", 32'(pc_inc_seen - p0), 2);
    check("nop_halt_no_start", 32'(start_seen - s0), 0);

    // Illegal class
    s0 = start_seen;
    do_instr(16'h7000, 0, 0, 1'b0, 1'b0);
    check("illegal_no_start", 32'(start_seen - s0), 0);

    // Memory timeout
    do_instr(16'h1111, MEM_TO, 0, 1'b0, 1'b0);

    // Stray done in fetch, then execution timeout
    do_instr(16'h2345, 2, EXEC_TO, 1'b1, 1'b0);

    // Boundary: ready and done on the last permitted cycles
    do_instr(16'h5123, MEM_TO - 1, EXEC_TO - 1, 1'b1, 1'b0);

    // Async reset in wait, then refetch
    do_instr(16'h3111, 0, 10, 1'b0, 1'b1);
    do_instr(16'h4C9E, 1, 2, 1'b0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      cls = 4'($urandom_range(1, 5));
      else if (r < 75) cls = 4'h0;
      else if (r < 83) cls = 4'hF;
      else             cls = 4'($urandom_range(6, 14));
      instr    = {cls, 12'($urandom)};
      mem_lat  = ($urandom_range(0, 9) == 0)  ? MEM_TO  : $urandom_range(0, 4);
      exec_lat = ($urandom_range(0, 14) == 0) ? EXEC_TO : $urandom_range(0, 8);
      do_instr(instr, mem_lat, exec_lat, 1'($urandom), ($urandom_range(0, 9) == 0));
    end

    check("pc_inc_total", pc_inc_seen, exp_pc_inc);
    check("start_total", start_seen, exp_start);
    check("strobes_onehot", onehot_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
